johnson_step_ctrl: RTL and testbench

Command-driven sequencer for a WIDTH-bit Johnson counter. It owns the counter register and steps it forward or in reverse by a requested number of steps. It accepts commands over a valid/ready handshake and reports completion with a one-cycle pulse. It supports loading a preset pattern, and it continuously checks the counter for illegal (non-Johnson) codes, entering a latched fault state when one is detected, as a fault-injection detector for the security test bench.

---
 rtl/johnson_step_ctrl.sv | 138 +++++++++++++
 tb/tb_johnson_step_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_step_ctrl.sv
// Command-driven forward/reverse stepper for a WIDTH-bit Johnson counter,
// with preset load and a latched fault state on any non-Johnson code.
module johnson_step_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  input  logic             abort,
  input  logic             fault_clear,
  output logic [WIDTH-1:0] counter_state,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MASK = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  // Legal Johnson code: at most one transition between adjacent bits (not circular).
  function automatic logic is_johnson(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] diff;
    diff = (v ^ {1'b0, v[WIDTH-1:1]}) & CNT_MASK;
    return ((diff & (diff - W_ONE)) == {WIDTH{1'b0}});
  endfunction

  function automatic logic [WIDTH-1:0] fwd_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ~v[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rev_step(input logic [WIDTH-1:0] v);
    return {~v[0], v[WIDTH-1:1]};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] counter_r;
  logic [CNT_W-1:0] remaining_r;
  logic             dir_r;
  logic             done_r;

  logic             counter_legal_s;
  logic             load_legal_s;
  logic [WIDTH-1:0] step_val_s;

  // Next counter value in the latched direction plus legality of current and preset codes.
  always_comb begin
    counter_legal_s = is_johnson(counter_r);
    load_legal_s    = is_johnson(load_value);
    if (dir_r) begin
      step_val_s = rev_step(counter_r);
    end else begin
      step_val_s = fwd_step(counter_r);
    end
  end

  assign cmd_ready     = (state_r == ST_IDLE) && !load_valid;
  assign counter_state = counter_r;
  assign busy          = (state_r == ST_RUN);
  assign fault         = (state_r == ST_FAULT);
  assign done          = done_r;

  // Sequencer: command accept, stepping, abort, preset load and fault latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      counter_r   <= {WIDTH{1'b0}};
      remaining_r <= CNT_ZERO;
      dir_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!counter_legal_s) begin
            state_r <= ST_FAULT;
          end else if (load_valid) begin
            // An illegal preset is still loaded so the offending code stays visible.
            counter_r <= load_value;
            state_r   <= load_legal_s ? ST_IDLE : ST_FAULT;
          end else if (cmd_valid) begin
            if (cmd_steps == CNT_ZERO) begin
              done_r <= 1'b1;
            end else begin
              remaining_r <= cmd_steps;
              dir_r       <= cmd_dir;
              state_r     <= ST_RUN;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!counter_legal_s) begin
            state_r <= ST_FAULT;
          end else if (abort) begin
            remaining_r <= CNT_ZERO;
            state_r     <= ST_IDLE;
          end else begin
            counter_r   <= step_val_s;
            remaining_r <= remaining_r - CNT_ONE;
            if (remaining_r == CNT_ONE) begin
              state_r <= ST_IDLE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clear) begin
            counter_r <= {WIDTH{1'b0}};
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_FAULT;
          end
        end
        default: begin
          state_r <= ST_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Scoreboard bench for johnson_step_ctrl: expected final counter values are
// queued per command and compared whenever done pulses.
module tb_johnson_step_ctrl;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_steps;
  logic       cmd_dir;
  logic       load_valid;
  logic [3:0] load_value;
  logic       abort;
  logic       fault_clear;
  logic [3:0] counter_state;
  logic       busy;
  logic       done;
  logic       fault;

  int num_checks;
  int num_fails;
  logic [3:0] exp_q[$];

  johnson_step_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_steps    (cmd_steps),
    .cmd_dir      (cmd_dir),
    .load_valid   (load_valid),
    .load_value   (load_value),
    .abort        (abort),
    .fault_clear  (fault_clear),
    .counter_state(counter_state),
    .busy         (busy),
    .done         (done),
    .fault        (fault)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_fwd(input logic [3:0] v);
    return {v[2:0], ~v[3]};
  endfunction

  function automatic logic [3:0] model_rev(input logic [3:0] v);
    return {~v[0], v[3:1]};
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_done", 32'(done), 32'd0);
      end else begin
        check_value("done_value", 32'(counter_state), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_cmd(input logic [7:0] n, input logic d, input logic expect_done,
                          input logic [3:0] final_v);
    cmd_steps = n;
    cmd_dir   = d;
    cmd_valid = 1'b1;
    if (expect_done) exp_q.push_back(final_v);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    load_value = v;
    load_valid = 1'b1;
    @(posedge clock); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) return;
    end
    check_value("done_timeout", 32'd0, 32'd1);
  endtask

  logic [3:0] fwd_tbl[4];
  logic [3:0] m;

  initial begin
    num_checks = 0;
    num_fails  = 0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_steps = 8'd0; cmd_dir = 1'b0;
    load_valid = 1'b0; load_value = 4'd0; abort = 1'b0; fault_clear = 1'b0;
    fwd_tbl[0] = 4'b0000; fwd_tbl[1] = 4'b0001; fwd_tbl[2] = 4'b0011; fwd_tbl[3] = 4'b0111;

    // Reset state
    #12;
    check_value("rst_counter", 32'(counter_state), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_fault", 32'(fault), 32'd0);
    check_value("rst_ready", 32'(cmd_ready), 32'd1);
    #5 reset = 1'b1;
    @(posedge clock); #1;

    // Forward run of 3 steps
    send_cmd(8'd3, 1'b0, 1'b1, 4'b0111);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_value("fwd_counter", 32'(counter_state), 32'(fwd_tbl[k]));
      check_value("fwd_busy", 32'(busy), (k < 3) ? 32'd1 : 32'd0);
      check_value("fwd_done", 32'(done), (k == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clock); #1;
    check_value("fwd_done_once", 32'(done), 32'd0);

    // Reverse wrap through a full period from 0000
    do_load(4'b0000);
    @(negedge clock);
    check_value("load_zero", 32'(counter_state), 32'd0);
    @(posedge clock); #1;
    send_cmd(8'd9, 1'b1, 1'b1, 4'b1000);
    m = 4'b0000;
    @(negedge clock);
    check_value("rev_hold_e0", 32'(counter_state), 32'(m));
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      m = model_rev(m);
      check_value("rev_counter", 32'(counter_state), 32'(m));
    end
    check_value("rev_done", 32'(done), 32'd1);
    check_value("rev_ready_in_done", 32'(cmd_ready), 32'd1);

    // Zero-step command issued back-to-back in the done cycle
    send_cmd(8'd0, 1'b0, 1'b1, 4'b1000);
    @(negedge clock);
    check_value("zero_done", 32'(done), 32'd1);
    check_value("zero_busy", 32'(busy), 32'd0);
    check_value("zero_counter", 32'(counter_state), 32'h8);
    @(posedge clock); #1;

    // Legal load then forward 2 steps
    do_load(4'b1100);
    @(negedge clock);
    check_value("load_legal", 32'(counter_state), 32'hC);
    check_value("load_no_fault", 32'(fault), 32'd0);
    @(posedge clock); #1;
    send_cmd(8'd2, 1'b0, 1'b1, 4'b0000);
    m = 4'b1100;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      m = model_fwd(m);
      check_value("load_run_counter", 32'(counter_state), 32'(m));
    end
    @(posedge clock); #1;

    // Load and command in the same IDLE cycle: load wins
    load_value = 4'b0011; load_valid = 1'b1;
    cmd_steps = 8'd1; cmd_valid = 1'b1;
    #1;
    check_value("load_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clock); #1;
    load_valid = 1'b0; cmd_valid = 1'b0;
    @(negedge clock);
    check_value("load_cmd_counter", 32'(counter_state), 32'h3);
    check_value("load_cmd_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;

    // Illegal load latches FAULT
    do_load(4'b0101);
    @(negedge clock);
    check_value("ill_fault", 32'(fault), 32'd1);
    check_value("ill_counter", 32'(counter_state), 32'h5);
    check_value("ill_ready", 32'(cmd_ready), 32'd0);
    check_value("ill_busy", 32'(busy), 32'd0);
    cmd_steps = 8'd3; cmd_valid = 1'b1; abort = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    cmd_valid = 1'b0; abort = 1'b0;
    @(negedge clock);
    check_value("ill_cmd_ignored", 32'(busy), 32'd0);
    check_value("ill_still_fault", 32'(fault), 32'd1);
    check_value("ill_frozen", 32'(counter_state), 32'h5);
    fault_clear = 1'b1;
    @(posedge clock); #1;
    fault_clear = 1'b0;
    @(negedge clock);
    check_value("clr_counter", 32'(counter_state), 32'd0);
    check_value("clr_fault", 32'(fault), 32'd0);
    check_value("clr_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;

    // Abort after the second step
    send_cmd(8'd5, 1'b0, 1'b0, 4'b0000);
    @(posedge clock); #1;
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    check_value("abort_counter", 32'(counter_state), 32'h3);
    check_value("abort_busy", 32'(busy), 32'd0);
    check_value("abort_done", 32'(done), 32'd0);
    repeat (4) @(negedge clock);
    check_value("abort_hold", 32'(counter_state), 32'h3);
    @(posedge clock); #1;

    // Asynchronous reset in the middle of a long run
    send_cmd(8'd20, 1'b0, 1'b0, 4'b0000);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_value("arst_counter", 32'(counter_state), 32'd0);
    check_value("arst_busy", 32'(busy), 32'd0);
    check_value("arst_done", 32'(done), 32'd0);
    check_value("arst_ready", 32'(cmd_ready), 32'd1);
    #10 reset = 1'b1;
    @(posedge clock); #1;
    send_cmd(8'd1, 1'b0, 1'b1, 4'b0001);
    wait_done(5);
    check_value("post_rst_counter", 32'(counter_state), 32'h1);
    @(posedge clock); #1;

    repeat (3) @(negedge clock);
    check_value("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
